pc_sequencer: RTL

Program-counter and instruction-fetch sequencer for the 16-bit CPU. It holds the PC, fetches one instruction word at a time from instruction memory over a request/ready handshake, and presents it to the execute stage. When execute accepts an instruction it reports whether that instruction was a jump. The jump condition from the jump-condition unit then chooses between the jump target and PC+1.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 84 ++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch/issue bus of the program-counter sequencer: instruction-memory
// request/ready, the instruction handed to execute, and the accept/jump
// feedback from execute. All buses are [0:15] (bit 0 is the MSB).
interface pc_sequencer_if;
  logic        o_memReq;
  logic [0:15] o_memAddr;
  logic        i_memReady;
  logic [0:15] i_memData;
  logic [0:15] o_instr;
  logic        o_instrValid;
  logic        i_take;
  logic        i_isJump;
  logic        i_cond;
  logic [0:15] i_jTarget;
  logic [0:15] o_pc;
  logic        o_jumped;
  logic [0:15] o_retired;

  // Sequencer side
  modport master (
    output o_memReq, o_memAddr, o_instr, o_instrValid, o_pc, o_jumped, o_retired,
    input  i_memReady, i_memData, i_take, i_isJump, i_cond, i_jTarget
  );

  // Memory / execute side
  modport slave (
    input  o_memReq, o_memAddr, o_instr, o_instrValid, o_pc, o_jumped, o_retired,
    output i_memReady, i_memData, i_take, i_isJump, i_cond, i_jTarget
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and single-word instruction fetch sequencer.
// IDLE (one cycle after reset) -> FETCH (request until memory ready)
// -> ISSUE (hold instruction until execute takes it) -> FETCH ...
// On take the PC moves to the jump target for a taken jump, else PC+1.
module pc_sequencer #(
  parameter logic [0:15] RESET_VEC = 16'h0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [0:15] pc_q, pc_d;
  logic [0:15] instr_q, instr_d;
  logic        jumped_q, jumped_d;
  logic [0:15] retired_q, retired_d;
  logic        taken;

  // Next-state logic: memory ready only matters in FETCH, execute inputs only in ISSUE
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    jumped_d  = 1'b0;
    retired_d = retired_q;
    taken     = bus.i_isJump & bus.i_cond;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.i_memReady) begin
          instr_d = bus.i_memData;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_take) begin
          pc_d      = taken ? bus.i_jTarget : pc_q + 16'd1;
          retired_d = retired_q + 16'd1;
          jumped_d  = taken;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VEC;
      instr_q   <= 16'h0000;
      jumped_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      jumped_q  <= jumped_d;
      retired_q <= retired_d;
    end
  end

  // Handshake strobes are pure state decodes, so they can never overlap
  assign bus.o_memReq     = (state_q == FETCH);
  assign bus.o_instrValid = (state_q == ISSUE);
  assign bus.o_memAddr    = pc_q;
  assign bus.o_pc         = pc_q;
  assign bus.o_instr      = instr_q;
  assign bus.o_jumped     = jumped_q;
  assign bus.o_retired    = retired_q;

endmodule
